dmem_resp: RTL and testbench

Multi-cycle data-memory responder for the pipelined RISC-V core's load/store port. It accepts one request at a time through a req/ready handshake and applies byte-lane writes from the 4-bit write-select. It returns read data, or a write acknowledge, a fixed number of cycles later with a one-cycle `rvalid` pulse. It replaces the zero-latency data memory when the core is built with stall-on-memory support.

---
 rtl/dmem_resp.sv | 131 +++++++++++++
 tb/tb_dmem_resp.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
// Multi-cycle data-memory responder for the core's load/store port. Accepts one
// request at a time through a req/ready handshake. It answers LATENCY cycles
// after acceptance with a one-cycle rvalid pulse. A read returns data on rd. A
// write commits the enabled byte lanes and is acknowledged with rvalid only.
//
// Ports
//   clk     in   clock, all state updates on the rising edge
//   reset   in   asynchronous active-low reset of control state and outputs
//   req     in   request strobe, accepted when ready is high at the edge
//   we      in   [3:0] byte write enables, all zero selects a read
//   a       in   [31:0] byte address, word index a[log2(DEPTH)+1:2]
//   wd      in   [31:0] write data, lane i = wd[8i+7:8i]
//   ready   out  responder can accept a request this cycle
//   rvalid  out  one-cycle completion pulse
//   rd      out  [31:0] read data, held until the next read completes
// -----------------------------------------------------------------------------
module dmem_resp #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [3:0]  we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rd
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [0:0] {StIdle, StWait} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_ready, w_ready_nxt;
   logic            r_rvalid, w_rvalid_nxt;
   logic [31:0]     r_rd;

   logic [AW-1:0]   r_addr;
   logic [3:0]      r_we;
   logic [31:0]     r_wd;
   logic [31:0]     r_mem [DEPTH];

   logic            w_accept;
   logic            w_commit;
   logic            w_unused_a;

   // Byte offset and bits above the word index do not select anything.
   assign w_unused_a = ^{a[31:AW+2], a[1:0]};

   // r_ready is low in reset and on the first edge afterwards, so no request
   // can be taken on the release edge.
   assign w_accept = req & r_ready;
   assign w_commit = (r_state == StWait) && (r_cnt == '0);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_ready_nxt  = r_ready;
      w_rvalid_nxt = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_ready_nxt = 1'b1;
            if (w_accept) begin
               w_state_nxt = StWait;
               w_cnt_nxt   = CNT_INIT;
               w_ready_nxt = 1'b0;
            end
         end
         StWait: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_state_nxt  = StIdle;
               w_ready_nxt  = 1'b1;
               w_rvalid_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_ready  <= 1'b0;
         r_rvalid <= 1'b0;
         r_rd     <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ready  <= w_ready_nxt;
         r_rvalid <= w_rvalid_nxt;
         if (w_commit && (r_we == 4'b0000)) begin
            r_rd <= r_mem[r_addr];
         end
      end
   end

   // Request capture and storage are not reset. A reset drops r_state to idle,
   // which removes w_commit, so a pending write is discarded.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr <= a[AW+1:2];
         r_we   <= we;
         r_wd   <= wd;
      end
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (r_we[i]) begin
               r_mem[r_addr][8*i +: 8] <= r_wd[8*i +: 8];
            end
         end
      end
   end

   assign ready  = r_ready;
   assign rvalid = r_rvalid;
   assign rd     = r_rd;

endmodule

// File: tb/tb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_dmem_resp
// Self-checking bench for dmem_resp. The main instance uses LATENCY=2 and is
// driven by directed and random requests. Each accepted request pushes its
// expected completion into a queue, and a monitor pops that queue whenever
// rvalid appears. The expected values come from a byte-array memory model. Two
// further instances with LATENCY=1 and LATENCY=5 check the timing of a
// write/read pair.
// -----------------------------------------------------------------------------
module tb_dmem_resp;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [3:0]  we;
   logic [31:0] a;
   logic [31:0] wd;
   logic        ready;
   logic        rvalid;
   logic [31:0] rd;

   logic [1:0]  sw_req;
   logic [1:0]  sw_ready;
   logic [1:0]  sw_rvalid;
   logic [3:0]  sw_we [2];
   logic [31:0] sw_a  [2];
   logic [31:0] sw_wd [2];
   logic [31:0] sw_rd [2];

   always #5 clk = ~clk;

   dmem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
      .clk    (clk),
      .reset  (rst_n),
      .req    (req),
      .we     (we),
      .a      (a),
      .wd     (wd),
      .ready  (ready),
      .rvalid (rvalid),
      .rd     (rd)
   );

   dmem_resp #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
      .clk    (clk),
      .reset  (rst_n),
      .req    (sw_req[0]),
      .we     (sw_we[0]),
      .a      (sw_a[0]),
      .wd     (sw_wd[0]),
      .ready  (sw_ready[0]),
      .rvalid (sw_rvalid[0]),
      .rd     (sw_rd[0])
   );

   dmem_resp #(.DEPTH(DEPTH), .LATENCY(5)) u_l5 (
      .clk    (clk),
      .reset  (rst_n),
      .req    (sw_req[1]),
      .we     (sw_we[1]),
      .a      (sw_a[1]),
      .wd     (sw_wd[1]),
      .ready  (sw_ready[1]),
      .rvalid (sw_rvalid[1]),
      .rd     (sw_rd[1])
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_read;
      logic [31:0] data;
      int          t0;
   } exp_t;

   exp_t        sb_q [$];
   exp_t        mon_e;
   bit   [7:0]  mb [DEPTH*4];
   logic [31:0] last_rd = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference memory: plain byte array, word index taken modulo DEPTH.
   task automatic model_access(input logic [3:0] w, input logic [31:0] addr,
                               input logic [31:0] d, output logic [31:0] res);
      int unsigned widx;
      int          base;
      widx = (addr >> 2) % DEPTH;
      base = int'(widx) * 4;
      if (w == 4'b0000) begin
         last_rd = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w[i]) mb[base+i] = d[8*i +: 8];
         end
      end
      res = last_rd;
   endtask

   // Called at a negedge. Holds req until ready is seen, then returns at the
   // negedge after the accepting edge with req still high.
   task automatic issue(input logic [3:0] w, input logic [31:0] addr, input logic [31:0] d,
                        input bit discard, output int t0);
      int          waited;
      logic [31:0] res;
      exp_t        en;
      waited = 0;
      t0     = -1;
      we     = w;
      a      = addr;
      wd     = d;
      req    = 1'b1;
      while (ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (ready !== 1'b1) begin
         chk("accept_timeout", 32'd0, 32'd1);
         req = 1'b0;
         return;
      end
      t0 = cyc + 1;
      if (!discard) begin
         model_access(w, addr, d, res);
         en.is_read = (w == 4'b0000);
         en.data    = res;
         en.t0      = t0;
         sb_q.push_back(en);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int waited;
      req    = 1'b0;
      waited = 0;
      while (sb_q.size() != 0 && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      chk("drain", sb_q.size(), 0);
   endtask

   // Directed write then read on one of the sweep instances.
   task automatic sweep(input int k, input int lat);
      int   t0;
      int   n_lo;
      int   waited;
      logic got;
      for (int pass = 0; pass < 2; pass++) begin
         sw_we[k] = (pass == 0) ? 4'hF : 4'h0;
         sw_a[k]  = 32'h44;
         sw_wd[k] = 32'hA5C3_0000 | lat;
         sw_req[k] = 1'b1;
         waited = 0;
         while (sw_ready[k] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         if (sw_ready[k] !== 1'b1) begin
            chk("sweep_accept_timeout", 32'd0, 32'd1);
            sw_req[k] = 1'b0;
            return;
         end
         t0 = cyc + 1;
         @(negedge clk);
         sw_req[k] = 1'b0;
         n_lo   = 0;
         waited = 0;
         got    = 1'b0;
         while (!got && waited < 20) begin
            if (sw_rvalid[k] === 1'b1) begin
               got = 1'b1;
            end else begin
               if (sw_ready[k] === 1'b0) n_lo++;
               @(negedge clk);
               waited++;
            end
         end
         chk("sweep_rvalid_seen", got, 1'b1);
         chk("sweep_latency", cyc - t0, lat);
         chk("sweep_ready_low", n_lo, lat);
         if (pass == 1) chk("sweep_read", sw_rd[k], 32'hA5C3_0000 | lat);
         @(negedge clk);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && rvalid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("rvalid_latency", cyc - mon_e.t0, LAT);
            chk(mon_e.is_read ? "read_data" : "write_rd_hold", rd, mon_e.data);
            chk("ready_with_rvalid", ready, 1'b1);
         end
      end
   end

   initial begin
      int t1, t2, t3, t;
      logic [31:0] r;
      logic [3:0]  w;
      rst_n = 1'b0;
      req   = 1'b0;
      we    = 4'h0;
      a     = 32'h0;
      wd    = 32'h0;
      sw_req = 2'b00;
      for (int k = 0; k < 2; k++) begin
         sw_we[k] = 4'h0;
         sw_a[k]  = 32'h0;
         sw_wd[k] = 32'h0;
      end

      // Reset
      repeat (3) @(negedge clk);
      chk("reset_ready", ready, 1'b0);
      chk("reset_rvalid", rvalid, 1'b0);
      chk("reset_rd", rd, 32'h0);
      rst_n = 1'b1;
      chk("ready_before_first_edge", ready, 1'b0);
      @(negedge clk);
      chk("ready_after_first_edge", ready, 1'b1);

      // Full-word write then read
      issue(4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, t);
      req = 1'b0;
      chk("write_ready_low", ready, 1'b0);
      drain();
      issue(4'h0, 32'h10, 32'h0, 1'b0, t);
      drain();

      // Byte lanes
      issue(4'hF, 32'h20, 32'h1122_3344, 1'b0, t);
      issue(4'b0010, 32'h20, 32'hAAAA_AAAA, 1'b0, t);
      issue(4'h0, 32'h20, 32'h0, 1'b0, t);
      issue(4'b1100, 32'h20, 32'h5566_BBBB, 1'b0, t);
      issue(4'h0, 32'h20, 32'h0, 1'b0, t);
      drain();

      // Back-to-back with req held; a[1:0]=3 aliases word 0x10
      issue(4'h0, 32'h10, 32'h0, 1'b0, t1);
      issue(4'h0, 32'h14, 32'h0, 1'b0, t2);
      issue(4'h0, 32'h13, 32'h0, 1'b0, t3);
      chk("b2b_spacing_1", t2 - t1, LAT + 1);
      chk("b2b_spacing_2", t3 - t2, LAT + 1);
      drain();

      // Reset in the middle of a write
      issue(4'hF, 32'h30, 32'h0, 1'b0, t);
      drain();
      issue(4'hF, 32'h30, 32'hCAFE_F00D, 1'b1, t);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      last_rd = 32'h0;
      repeat (2) @(negedge clk);
      chk("midreset_ready", ready, 1'b0);
      chk("midreset_rvalid", rvalid, 1'b0);
      chk("midreset_rd", rd, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      issue(4'h0, 32'h30, 32'h0, 1'b0, t);
      drain();

      // Address wrap
      issue(4'hF, 32'h100, 32'h0BAD_C0DE, 1'b0, t);
      issue(4'h0, 32'h000, 32'h0, 1'b0, t);
      drain();

      // Random: fill every word, then mixed traffic with gaps and junk address bits
      for (int i = 0; i < DEPTH; i++) begin
         r = $urandom;
         issue(4'hF, (r & ~32'h0000_00FC) | (i << 2), $urandom, 1'b0, t);
         if ($urandom_range(0, 1) == 1) begin
            req = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      for (int i = 0; i < 150; i++) begin
         w = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
         issue(w, $urandom, $urandom, 1'b0, t);
         if ($urandom_range(0, 2) == 0) begin
            req = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
         end
      end
      drain();

      // Latency sweep
      sweep(0, 1);
      sweep(1, 5);

      repeat (5) @(negedge clk);
      chk("final_queue_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
